// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers 9-bit TX words from the CPU side and drains them,
// one frame at a time, into the UART.
//
// Ports:
//   SCLK, SRES      clock (rising edge), asynchronous active-low reset
//   enable          drain enable; when low, no new frame is started
//   flush           synchronous FIFO clear; an in-flight frame still completes
//   push, push_data CPU-side write strobe and 9-bit TX word
//   ucr             UART control/status word; only bit 1 (TxIP) is used
//   write_utdr      load strobe to UART UTDR (LOAD state)
//   set_ucr         set-bits strobe to UART UCR (START state, sets TxIP)
//   data            bus to the UART data input; zero unless grant is high
//   grant           high while this block owns the UART bus and strobes
//   full, empty     FIFO status, decoded from level
//   level           number of stored words, 0..DEPTH
//   overflow        sticky: a push was dropped while full (cleared by flush)
//
// FSM states:
//   state       | meaning
//   S_IDLE      | no frame active; pops the head word when a frame can start
//   S_LOAD      | drives hold onto data and pulses write_utdr
//   S_START     | drives 16'h0002 onto data and pulses set_ucr (sets TxIP)
//   S_WAIT_SET  | waits for the UART to report TxIP
//   S_WAIT_DONE | waits for TxIP to clear (frame finished)

module uart_tx_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          SCLK,
  input  logic          SRES,
  input  logic          enable,
  input  logic          flush,
  input  logic          push,
  input  logic [8:0]    push_data,
  input  logic [5:0]    ucr,
  output logic          write_utdr,
  output logic          set_ucr,
  output logic [15:0]   data,
  output logic          grant,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_SET,
    S_WAIT_DONE
  } state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  state_t        state_q;
  state_t        state_d;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [8:0]    hold;
  logic          push_ok;
  logic          pop;
  logic          txip;
  logic          unused_ucr;

  assign txip       = ucr[1];
  assign unused_ucr = ^{ucr[5:2], ucr[0]};

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  // Acceptance uses the registered full flag; a same-cycle pop does not
  // make room for the incoming word.
  assign push_ok = push & ~full;

  // FIFO storage carries no reset; contents are never observed while empty.
  always_ff @(posedge SCLK) begin
    if (push_ok && !flush) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge SCLK or negedge SRES) begin
    if (!SRES) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && full) begin
        overflow <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge SCLK or negedge SRES) begin
    if (!SRES) begin
      hold <= '0;
    end else if (pop) begin
      hold <= mem[rptr];
    end
  end

  always_ff @(posedge SCLK or negedge SRES) begin
    if (!SRES) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    write_utdr = 1'b0;
    set_ucr    = 1'b0;
    grant      = 1'b0;
    data       = 16'h0000;
    case (state_q)
      S_IDLE: begin
        // flush wins over pop, so no frame starts in a flush cycle.
        if (enable && !empty && !flush && !txip) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        grant      = 1'b1;
        write_utdr = 1'b1;
        data       = {7'b0, hold};
        state_d    = S_START;
      end
      S_START: begin
        grant   = 1'b1;
        set_ucr = 1'b1;
        data    = 16'h0002;
        state_d = S_WAIT_SET;
      end
      S_WAIT_SET: begin
        if (txip) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!txip) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed vectors, a small UART model that raises
// TxIP after set_ucr for busy_len cycles, and logs of every UTDR write.

module tb_uart_tx_feeder;

  logic        SCLK;
  logic        SRES;
  logic        enable;
  logic        flush;
  logic        push;
  logic [8:0]  push_data;
  logic [5:0]  ucr;
  logic        write_utdr;
  logic        set_ucr;
  logic [15:0] data;
  logic        grant;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;

  logic        txip_model;
  logic        txip_force;
  int          busy_cnt;
  int          busy_len;
  int          bad_set;
  int          bad_grant;
  logic [15:0] wr_q[$];

  int          n_checks;
  int          n_errors;

  uart_tx_feeder #(.DEPTH(8), .AW(3)) dut (
    .SCLK       (SCLK),
    .SRES       (SRES),
    .enable     (enable),
    .flush      (flush),
    .push       (push),
    .push_data  (push_data),
    .ucr        (ucr),
    .write_utdr (write_utdr),
    .set_ucr    (set_ucr),
    .data       (data),
    .grant      (grant),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  assign ucr = {3'b000, 1'b0, txip_model | txip_force, 1'b0};

  // UART model and write log, sampled mid-cycle away from the active edge.
  always @(negedge SCLK or negedge SRES) begin
    if (!SRES) begin
      txip_model <= 1'b0;
      busy_cnt   <= 0;
      bad_set    <= 0;
      bad_grant  <= 0;
    end else begin
      if (write_utdr) begin
        wr_q.push_back(data);
      end
      if ((write_utdr || set_ucr) && !grant) begin
        bad_grant <= bad_grant + 1;
      end
      if (set_ucr) begin
        if (data != 16'h0002) begin
          bad_set <= bad_set + 1;
        end
        txip_model <= 1'b1;
        busy_cnt   <= busy_len;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          txip_model <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  // Wait until n words have been written and the UART model is idle again,
  // then give the FSM a few cycles to return to IDLE.
  task automatic wait_drain(input string tag, input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_q.size() >= n && !txip_model && busy_cnt == 0 && !set_ucr && !write_utdr) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'b0, ok}, 32'd1);
    repeat (3) tick();
  endtask

  task automatic push_word(input logic [8:0] w);
    push      = 1'b1;
    push_data = w;
    tick();
    push      = 1'b0;
  endtask

  int strobes;
  logic [8:0] w;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    SRES       = 1'b0;
    enable     = 1'b0;
    flush      = 1'b0;
    push       = 1'b0;
    push_data  = '0;
    txip_force = 1'b0;
    busy_len   = 100;

    // Reset state
    #13;
    check("rst_empty",      {31'b0, empty},      32'd1);
    check("rst_full",       {31'b0, full},       32'd0);
    check("rst_level",      {28'b0, level},      32'd0);
    check("rst_overflow",   {31'b0, overflow},   32'd0);
    check("rst_write_utdr", {31'b0, write_utdr}, 32'd0);
    check("rst_set_ucr",    {31'b0, set_ucr},    32'd0);
    check("rst_grant",      {31'b0, grant},      32'd0);
    check("rst_data",       {16'b0, data},       32'h0);
    @(posedge SCLK);
    #1;
    SRES = 1'b1;
    tick();

    // Single word with a 100-cycle frame
    enable = 1'b1;
    push_word(9'h0A5);
    check("single_level_after_push", {28'b0, level},      32'd1);
    check("single_no_early_write",   {31'b0, write_utdr}, 32'd0);
    tick();
    check("single_write_utdr", {31'b0, write_utdr}, 32'd1);
    check("single_data_load",  {16'b0, data},       32'h00A5);
    check("single_grant_load", {31'b0, grant},      32'd1);
    check("single_set_ucr_lo", {31'b0, set_ucr},    32'd0);
    check("single_empty_pop",  {31'b0, empty},      32'd1);
    tick();
    check("single_set_ucr",     {31'b0, set_ucr},    32'd1);
    check("single_write_off",   {31'b0, write_utdr}, 32'd0);
    check("single_data_start",  {16'b0, data},       32'h0002);
    tick();
    check("single_grant_wait",  {31'b0, grant},      32'd0);
    check("single_data_wait",   {16'b0, data},       32'h0);
    wait_drain("single_timeout", 1, 300);
    check("single_writes", wr_q.size(), 32'd1);
    check("single_empty",  {31'b0, empty}, 32'd1);
    check("single_grant",  {31'b0, grant}, 32'd0);

    // Fill and overflow
    busy_len = 4;
    wr_q.delete();
    enable = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      w = 9'(i);
      push_word(w);
    end
    check("fill_full",      {31'b0, full},     32'd1);
    check("fill_level",     {28'b0, level},    32'd8);
    check("fill_no_ovf",    {31'b0, overflow}, 32'd0);
    push_word(9'd9);
    check("ovf_set",        {31'b0, overflow}, 32'd1);
    check("ovf_level",      {28'b0, level},    32'd8);
    enable = 1'b1;
    wait_drain("fill_timeout", 8, 400);
    repeat (20) tick();
    check("fill_writes", wr_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      check($sformatf("fill_word[%0d]", i), {16'b0, wr_q[i]}, 32'(i + 1));
    end
    check("fill_empty",  {31'b0, empty},    32'd1);
    check("ovf_sticky",  {31'b0, overflow}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_clears_ovf", {31'b0, overflow}, 32'd0);

    // Pointer wrap: 5 in/out, then 6 in/out
    wr_q.delete();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = 9'h110 + 9'(i);
      push_word(w);
    end
    check("wrap_a_level", {28'b0, level}, 32'd5);
    enable = 1'b1;
    wait_drain("wrap_a_timeout", 5, 300);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w = 9'h020 + 9'(i);
      push_word(w);
    end
    check("wrap_b_level", {28'b0, level}, 32'd6);
    enable = 1'b1;
    wait_drain("wrap_b_timeout", 11, 300);
    check("wrap_writes", wr_q.size(), 32'd11);
    for (int i = 0; i < 11 && i < wr_q.size(); i++) begin
      check($sformatf("wrap_word[%0d]", i), {16'b0, wr_q[i]},
            (i < 5) ? 32'h110 + 32'(i) : 32'h020 + 32'(i - 5));
    end
    check("wrap_level", {28'b0, level}, 32'd0);

    // Push coinciding with pop, then flush during WAIT_DONE
    busy_len = 20;
    wr_q.delete();
    enable = 1'b0;
    push_word(9'h031);
    push_word(9'h032);
    push_word(9'h033);
    check("simul_level_pre", {28'b0, level}, 32'd3);
    enable    = 1'b1;
    push_word(9'h034);
    check("simul_level_same", {28'b0, level},      32'd3);
    check("simul_load",       {31'b0, write_utdr}, 32'd1);
    check("simul_load_data",  {16'b0, data},       32'h0031);
    push_word(9'h035);
    check("simul_level_4",    {28'b0, level},      32'd4);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_level", {28'b0, level}, 32'd0);
    check("flush_empty", {31'b0, empty}, 32'd1);
    wait_drain("flush_timeout", 1, 200);
    repeat (10) tick();
    check("flush_writes", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) begin
      check("flush_word", {16'b0, wr_q[0]}, 32'h0031);
    end

    // Busy UART held externally
    wr_q.delete();
    txip_force = 1'b1;
    push_word(9'h041);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      strobes += int'(write_utdr) + int'(set_ucr) + int'(grant);
      tick();
    end
    check("busy_no_strobes", strobes, 32'd0);
    check("busy_level",      {28'b0, level}, 32'd1);
    txip_force = 1'b0;
    tick();
    check("busy_release_load", {31'b0, write_utdr}, 32'd1);
    check("busy_release_data", {16'b0, data},       32'h0041);
    wait_drain("busy_timeout", 1, 200);
    check("busy_writes", wr_q.size(), 32'd1);

    check("set_ucr_data_all", bad_set,   32'd0);
    check("strobe_grant_all", bad_grant, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
